data_c_pipe_sync_chain: RTL and testbench
=========================================

// Module: data_c_pipe_sync_chain
// PURPOSE
//  LAT-stage elastic valid/ready pipeline with per-stage sideband capture, flush and occupancy.
//  - Data path: DSIZE payload at full throughput (1 beat/cycle).
//  - Sideband: stage k samples its own side input on each token entry.
//  - Used wherever a stream must be delayed by a fixed, balanced number of register stages,
//    e.g. alongside multi-cycle arithmetic that consumes the per-stage side data.
// PARAMETERS
//  LAT    4   number of pipeline stages, >=1
//  DSIZE  32  stream payload width
//  SSIZE  32  per-stage sideband width
// PORTS
//  clock      in   1            single clock; all logic on posedge
//  rst_n      in   1            asynchronous active-low reset
//  flush      in   1            synchronous drop of all in-flight tokens
//  in_valid   in   1            upstream valid
//  in_ready   out  1            upstream ready
//  in_data    in   DSIZE        upstream payload
//  in_datas   in   SSIZE x LAT  sideband input, element k sampled by stage k
//  out_datas  out  SSIZE x LAT  sideband held by stage k
//  out_valid  out  1            downstream valid (stage LAT-1)
//  out_ready  in   1            downstream ready
//  out_data   out  DSIZE        downstream payload
//  stage_valid out LAT          per-stage occupied flag (bit k = stage k)
//  occupancy  out  $clog2(2*LAT+1)  tokens currently held
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valids, out_valid, stage_valid, occupancy, out_data and out_datas = 0.
//  - Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Stage k (base build):
//    - ready_k = !valid_k | ready_{k+1}; ready_LAT = out_ready.
//    - On accept: data_k <= data_{k-1}, valid_k <= 1, side_k <= in_datas[k].
//    - Else, if ready_{k+1}: valid_k <= 0.
//  - Latency and throughput:
//    - in_fire at cycle t -> out_valid at t+LAT, given no stall.
//    - Sustained 1 beat/cycle; capacity LAT.
//    - Full chain with in_fire & out_fire in the same cycle: no bubble.
//  - out_datas[k]: updates only when stage k accepts a token; otherwise holds. Not cleared by flush.
//  - Flush:
//    - flush=1 forces in_ready=0 that cycle; input beat not accepted.
//    - Next cycle: all valids=0, occupancy=0.
//    - out_fire coinciding with flush still counts as delivered.
//  - occupancy:
//    - +1 on in_fire, -1 on out_fire, unchanged when both occur.
//    - Flush overrides to 0.
//    - Never exceeds capacity.
//  - Ordering: tokens leave strictly in entry order; no drop and no duplication except on flush.
//  - Reset mid-operation: in-flight tokens discarded immediately; out_valid=0 while rst_n=0.
// CONFIGURATION
//  PIPE_SYNC_CHAIN_SKID_EN defined:
//    - Each stage is a 2-entry skid slice; ready_k is registered (= entries_k<2), so there is
//      no combinational ready path across stages.
//    - Capacity 2*LAT; latency LAT cycles when unstalled; throughput 1/cycle.
//    - side_k captured on entry into either slot; out_datas[k] = value of latest entry.
//  Not defined:
//    - Base build as above; ready ripples combinationally from out_ready to in_ready.
//    - Capacity LAT; occupancy upper bits stay 0.
// TESTING
//  - Latency: LAT=4, out_ready=1, single beat 0xA5 at t0 -> out_valid=1, out_data=0xA5 at t0+4, one cycle only.
//  - Streaming: 100 beats 0..99 back-to-back, out_ready=1 -> 100 beats in order, no gaps,
//    occupancy steady at 4.
//  - Backpressure:
//    - out_ready=0, in_valid=1 -> in_ready drops after 4 accepts (8 with SKID_EN); occupancy=4 (8).
//    - Release out_ready -> order preserved.
//  - Sideband: in_datas[k]=k*16+beat each cycle -> out_datas[2] equals value present when
//    the current stage-2 token entered; holds while stalled.
//  - Flush: 3 tokens in flight, flush=1 with in_valid=1 -> in_ready=0; next cycle stage_valid=0,
//    occupancy=0, beat dropped; next beat passes normally.
//  - Reset: assert rst_n=0 mid-stream, async -> out_valid=0 and occupancy=0 before the next clock edge; restart clean.

Source files
------------

// File: rtl/data_c_pipe_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : data_c_pipe_sync_chain
// Brief    : LAT-stage elastic valid/ready pipeline with per-stage sideband
//            capture, synchronous flush and occupancy count.
//            Optional macro PIPE_SYNC_CHAIN_SKID_EN turns every stage into a
//            2-entry skid slice with registered ready (capacity 2*LAT).
// Revision : 1.0 - initial release
// ============================================================================
module data_c_pipe_sync_chain #(
  parameter int LAT   = 4,
  parameter int DSIZE = 32,
  parameter int SSIZE = 32
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DSIZE-1:0]              in_data,
  input  logic [LAT-1:0][SSIZE-1:0]     in_datas,
  output logic [LAT-1:0][SSIZE-1:0]     out_datas,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DSIZE-1:0]              out_data,
  output logic [LAT-1:0]                stage_valid,
  output logic [$clog2(2*LAT+1)-1:0]    occupancy
);

  localparam int c_occ_w = $clog2(2*LAT+1);

  // Per-stage view shared by both builds: occupied flag, head payload, ready.
  logic [LAT-1:0]            w_sv;
  logic [LAT-1:0][DSIZE-1:0] w_sd;
  logic [LAT-1:0]            w_rdy;
  // Links between neighbouring stages.
  logic [LAT-1:0]            w_up_valid;
  logic [LAT-1:0][DSIZE-1:0] w_up_data;
  logic [LAT-1:0]            w_dn_ready;
  logic [LAT-1:0]            w_push;
  logic                      w_in_fire;
  logic                      w_out_fire;

  logic [LAT-1:0][SSIZE-1:0] r_side;
  logic [c_occ_w-1:0]        r_occ;

  for (genvar k = 0; k < LAT; k++) begin : g_link
    if (k == 0) begin : g_head
      assign w_up_valid[k] = in_valid;
      assign w_up_data[k]  = in_data;
    end else begin : g_body
      assign w_up_valid[k] = w_sv[k-1];
      assign w_up_data[k]  = w_sd[k-1];
    end
    if (k == LAT-1) begin : g_tail
      assign w_dn_ready[k] = out_ready;
    end else begin : g_mid
      assign w_dn_ready[k] = w_rdy[k+1];
    end
  end

  // Flush blocks every transfer so nothing lands in a stage that is being cleared.
  assign w_push     = w_up_valid & w_rdy & {LAT{~flush}};
  assign in_ready   = w_rdy[0] & ~flush;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

`ifdef PIPE_SYNC_CHAIN_SKID_EN
  logic [LAT-1:0][1:0]       r_cnt;
  logic [LAT-1:0][DSIZE-1:0] r_hd;
  logic [LAT-1:0][DSIZE-1:0] r_tl;
  logic [LAT-1:0]            w_pop;

  for (genvar k = 0; k < LAT; k++) begin : g_skid_view
    assign w_sv[k]  = (r_cnt[k] != 2'd0);
    assign w_sd[k]  = r_hd[k];
    // Ready depends only on this stage's own entry count, never on neighbours.
    assign w_rdy[k] = ~r_cnt[k][1];
  end

  assign w_pop = w_sv & w_dn_ready;

  // Two-slot skid buffer per stage: head feeds downstream, tail absorbs a stall.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_hd  <= '0;
      r_tl  <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (flush) begin
          r_cnt[k] <= 2'd0;
        end else begin
          case ({w_push[k], w_pop[k]})
            2'b10: begin
              if (r_cnt[k] == 2'd0) begin
                r_hd[k]  <= w_up_data[k];
                r_cnt[k] <= 2'd1;
              end else begin
                r_tl[k]  <= w_up_data[k];
                r_cnt[k] <= 2'd2;
              end
            end
            2'b01: begin
              if (r_cnt[k] == 2'd2) begin
                r_hd[k]  <= r_tl[k];
                r_cnt[k] <= 2'd1;
              end else begin
                r_cnt[k] <= 2'd0;
              end
            end
            2'b11: begin
              // Push only happens with a free slot, so exactly one entry is replaced.
              r_hd[k] <= w_up_data[k];
            end
            default: begin
            end
          endcase
        end
      end
    end
  end
`else
  localparam logic [LAT-1:0] c_ones = '1;

  logic [LAT-1:0]            r_valid;
  logic [LAT-1:0][DSIZE-1:0] r_data;

  for (genvar k = 0; k < LAT; k++) begin : g_base_view
    assign w_sv[k]  = r_valid[k];
    assign w_sd[k]  = r_data[k];
    // A stage can accept when any stage at or after it has a hole, or the sink drains.
    assign w_rdy[k] = out_ready | (|(~r_valid & (c_ones << k)));
  end

  // Single-register stages: load on accept, empty when the token moves on.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_push[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= w_up_data[k];
        end else if (w_dn_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end
`endif

  // Sideband sample: stage k grabs its own side input whenever it takes a token.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_side <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (w_push[k]) begin
          r_side[k] <= in_datas[k];
        end
      end
    end
  end

  // Token count: +1 in, -1 out, cleared by flush.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case ({w_in_fire, w_out_fire})
        2'b10:   r_occ <= r_occ + c_occ_w'(1);
        2'b01:   r_occ <= r_occ - c_occ_w'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign out_valid   = w_sv[LAT-1];
  assign out_data    = w_sd[LAT-1];
  assign out_datas   = r_side;
  assign stage_valid = w_sv;
  assign occupancy   = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_data_c_pipe_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_c_pipe_sync_chain
// Brief    : Directed self-checking bench for data_c_pipe_sync_chain
//            (LAT=4, DSIZE=32, SSIZE=32, base build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_c_pipe_sync_chain;

  localparam int LAT = 4;
  localparam int DW  = 32;
  localparam int SW  = 32;
  localparam int OW  = $clog2(2*LAT+1);

  logic                  clock;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic [LAT-1:0][SW-1:0] in_datas;
  logic [LAT-1:0][SW-1:0] out_datas;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic [LAT-1:0]        stage_valid;
  logic [OW-1:0]         occupancy;

  int n_chk  = 0;
  int n_pass = 0;

  data_c_pipe_sync_chain #(.LAT(LAT), .DSIZE(DW), .SSIZE(SW)) u_dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_datas    (in_datas),
    .out_datas   (out_datas),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stage_valid (stage_valid),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_side(input int b);
    for (int k = 0; k < LAT; k++) in_datas[k] = SW'(k*16 + b);
  endtask

  // One isolated beat: must appear exactly LAT cycles later, for one cycle only.
  task automatic probe_beat(input logic [DW-1:0] d, input string tag);
    int lat;
    int cnt;
    logic [DW-1:0] got;
    lat = 0; cnt = 0; got = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    step();
    in_valid  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (out_valid) begin
        cnt++;
        if (lat == 0) begin
          lat = i;
          got = out_data;
        end
      end
      step();
    end
    check_eq({tag, "_lat"},  64'(lat), 64'(LAT));
    check_eq({tag, "_data"}, 64'(got), 64'(d));
    check_eq({tag, "_once"}, 64'(cnt), 64'd1);
  endtask

  initial begin
    int rcv, errs, gaps, occbad, acc, seen;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; in_datas = '0;

    // Reset state
    step();
    check_eq("rst_out_valid",   64'(out_valid),    64'd0);
    check_eq("rst_occupancy",   64'(occupancy),    64'd0);
    check_eq("rst_stage_valid", 64'(stage_valid),  64'd0);
    check_eq("rst_out_data",    64'(out_data),     64'd0);
    check_eq("rst_out_datas",   64'(|out_datas),   64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Latency of a single beat
    probe_beat(32'hA5, "lat_a5");

    // Streaming 0..99 back-to-back
    rcv = 0; errs = 0; gaps = 0; occbad = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 120; c++) begin
      in_valid = (c < 100);
      in_data  = DW'(c);
      step();
      if (out_valid) begin
        if (out_data != DW'(rcv)) errs++;
        rcv++;
      end else if (rcv > 0 && rcv < 100) begin
        gaps++;
      end
      if (c >= 3 && c <= 99 && occupancy != OW'(4)) occbad++;
    end
    in_valid = 1'b0;
    check_eq("stream_count",  64'(rcv),       64'd100);
    check_eq("stream_order",  64'(errs),      64'd0);
    check_eq("stream_gaps",   64'(gaps),      64'd0);
    check_eq("stream_occ4",   64'(occbad),    64'd0);
    check_eq("stream_empty",  64'(occupancy), 64'd0);

    // Backpressure: fills to 4 then stops accepting
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(200 + acc);
      #1;
      if (in_ready) acc++;
      step();
    end
    check_eq("bp_accepts",     64'(acc),         64'd4);
    check_eq("bp_occupancy",   64'(occupancy),   64'd4);
    check_eq("bp_in_ready",    64'(in_ready),    64'd0);
    check_eq("bp_stage_valid", 64'(stage_valid), 64'hF);
    in_valid = 1'b0; out_ready = 1'b1; rcv = 0; errs = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (out_data != DW'(200 + rcv)) errs++;
        rcv++;
      end
      step();
    end
    check_eq("bp_drain_count", 64'(rcv),  64'd4);
    check_eq("bp_drain_order", 64'(errs), 64'd0);

    // Sideband: stage 2 keeps the side value present when its token entered
    out_ready = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      set_side(b);
      in_valid = 1'b1;
      in_data  = DW'(b);
      step();
      if (b >= 3) check_eq("side_stage2", 64'(out_datas[2]), 64'(32 + b));
    end
    out_ready = 1'b0; in_valid = 1'b0;
    for (int b = 7; b <= 10; b++) begin
      set_side(b);
      step();
    end
    check_eq("side_hold", 64'(out_datas[2]), 64'd38);
    out_ready = 1'b1;
    repeat (6) step();

    // Flush with 3 tokens in flight
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_data  = DW'(32'h10 + b);
      step();
    end
    check_eq("fl_pre_occ",   64'(occupancy),   64'd3);
    check_eq("fl_pre_stage", 64'(stage_valid), 64'h7);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h99;
    #1;
    check_eq("fl_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_stage_valid", 64'(stage_valid), 64'd0);
    check_eq("fl_occupancy",   64'(occupancy),   64'd0);
    check_eq("fl_out_valid",   64'(out_valid),   64'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen++;
      step();
    end
    check_eq("fl_dropped", 64'(seen), 64'd0);
    probe_beat(32'h77, "fl_next");

    // Asynchronous reset in the middle of a stream
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(32'h300 + c);
      step();
    end
    check_eq("mr_pre_valid", 64'(out_valid), 64'd1);
    check_eq("mr_pre_occ",   64'(occupancy), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_out_valid",   64'(out_valid),   64'd0);
    check_eq("mr_occupancy",   64'(occupancy),   64'd0);
    check_eq("mr_stage_valid", 64'(stage_valid), 64'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    probe_beat(32'h5A, "mr_restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
